// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and ALU operation encoding.
// Pure type definitions, no logic.
// Used by the ALU file interface and every ALU initiator.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

endpackage

// File: rtl/alu_mult_seq_if.sv
// alu_file_if: request/result bundle between an ALU initiator and the shared ALU.
// Purely combinational: result follows operands within the same cycle.
// No flow control; the initiator owns the ALU while it drives it.
interface alu_file_if;

  cpu_types_pkg::word_t  port_a;
  cpu_types_pkg::word_t  port_b;
  cpu_types_pkg::aluop_t ALUOP;
  cpu_types_pkg::word_t  output_port;
  logic                  zero;
  logic                  negative;
  logic                  overflow;

  // Initiator side (drives operands and opcode, reads the result).
  modport tb (
    output port_a, port_b, ALUOP,
    input  output_port, zero, negative, overflow
  );

  // ALU side.
  modport alu (
    input  port_a, port_b, ALUOP,
    output output_port, zero, negative, overflow
  );

endinterface

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: shift-and-add 32x32 multiplier (low 32 bits) using the shared ALU as adder.
// Latency: done in cycle 33 after accepted start; with MULT_EARLY_EXIT_EN, cycle max(1,bitlen(opb))+1.
// No backpressure: start is sampled only in IDLE and ignored otherwise (no queueing).
module alu_mult_seq
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  start,
  input  word_t opa,
  input  word_t opb,
  output logic  busy,
  output logic  done,
  output word_t product,
  alu_file_if.tb aluif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q;
  word_t      mcand_q, mcand_d;
  word_t      mplier_q, mplier_d;
  word_t      acc_q, acc_d;
  logic [4:0] cnt_q, cnt_d;
  logic       busy_q;
  logic       done_q;
  word_t      product_q;
  logic       last_iter;

  // ALU is only loaded with real operands while iterating; otherwise it adds 0+0.
  assign aluif.ALUOP  = ALU_ADD;
  assign aluif.port_a = (state_q == ST_RUN) ? acc_q : '0;
  assign aluif.port_b = ((state_q == ST_RUN) && mplier_q[0]) ? mcand_q : '0;

  // Per-iteration next values; ALU overflow and bits shifted out of mcand are dropped.
  always_comb begin
    acc_d    = aluif.output_port;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    cnt_d    = cnt_q + 5'd1;
`ifdef MULT_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain; the accumulator is already final.
    last_iter = (cnt_q == 5'd31) || (mplier_d == '0);
`else
    last_iter = (cnt_q == 5'd31);
`endif
  end

  // Control FSM with registered busy/done/product.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= opa;
            mplier_q <= opb;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (last_iter) begin
            // The final sum is on the ALU output this cycle; capture it directly.
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
